// File: rtl/adt7420_sample_scheduler.sv
// adt7420_sample_scheduler
// Schedules periodic ADT7420 temperature reads through the I2C master, waits
// out sensor power-up, supervises each read for bus errors and timeouts,
// averages good samples over 4 taps and derives a hysteretic fan request.
//
// Ports (clk_200kHz domain):
//    clk_200kHz   in   system clock
//    reset_n      in   synchronous active-low reset
//    rd_req       out  one-cycle read request to the I2C master
//    rd_done      in   one-cycle pulse, read finished and rd_data valid
//    rd_ack_err   in   one-cycle pulse, NACK or bus error on current read
//    rd_data      in   raw temperature register, [15:3] signed 13-bit temp
//    temperature  out  signed 4-sample average, 0.0625 C/LSB
//    temp_valid   out  at least one good sample has been averaged
//    fan_on       out  hysteretic fan request, forced high during fault
//    fault        out  MAX_ERR consecutive failed reads
//    sample_cnt   out  good samples taken, wraps 255 -> 0
module adt7420_sample_scheduler #(
   parameter logic        [11:0] POWER_UP_TIME = 12'd1950,
   parameter logic        [15:0] SAMPLE_PERIOD = 16'd20000,
   parameter logic        [11:0] TIMEOUT       = 12'd1000,
   parameter logic signed [12:0] T_ON          = 13'sd480,
   parameter logic signed [12:0] T_OFF         = 13'sd432,
   parameter logic        [1:0]  MAX_ERR       = 2'd3
) (
   input  logic               clk_200kHz,
   input  logic               reset_n,
   output logic               rd_req,
   input  logic               rd_done,
   input  logic               rd_ack_err,
   input  logic        [15:0] rd_data,
   output logic signed [12:0] temperature,
   output logic               temp_valid,
   output logic               fan_on,
   output logic               fault,
   output logic        [7:0]  sample_cnt
);

   localparam logic [2:0] POWERUP = 3'd0;
   localparam logic [2:0] REQ     = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] PROCESS = 3'd3;
   localparam logic [2:0] FAIL    = 3'd4;
   localparam logic [2:0] IDLE    = 3'd5;

   // Sign-extend a 13-bit sample to the 15-bit accumulator width.
   function automatic logic signed [14:0] ext15(input logic signed [12:0] v);
      return {{2{v[12]}}, v};
   endfunction

   logic        [2:0]  stateR;
   logic        [15:0] cntR;
   logic        [1:0]  errCntR;
   logic signed [12:0] sampleR;
   logic signed [12:0] tapR     [0:3];
   logic signed [12:0] tapNextS [0:3];
   logic signed [14:0] sumS;
   logic signed [12:0] avgS;
   logic        [16:0] cntPlusS;
   logic        [1:0]  errNextS;
   logic        [2:0]  unusedLsbS;

   // The three low register bits carry flags, not temperature.
   assign unusedLsbS = rd_data[2:0];

   // Next tap contents, averaged value, saturating error count and counter+1.
   always_comb begin
      cntPlusS = {1'b0, cntR} + 17'd1;
      if (!temp_valid) begin
         // First good sample since reset fills every tap so the average starts settled.
         for (int i = 0; i < 4; i++) begin
            tapNextS[i] = sampleR;
         end
      end else begin
         tapNextS[0] = sampleR;
         tapNextS[1] = tapR[0];
         tapNextS[2] = tapR[1];
         tapNextS[3] = tapR[2];
      end
      sumS = ext15(tapNextS[0]) + ext15(tapNextS[1]) + ext15(tapNextS[2]) + ext15(tapNextS[3]);
      // Bits [14:2] of the signed sum equal sum >>> 2 truncated to 13 bits.
      avgS = sumS[14:2];
      if (errCntR != MAX_ERR) begin
         errNextS = errCntR + 2'd1;
      end else begin
         errNextS = errCntR;
      end
   end

   // Sequencer: power-up wait, request, supervised wait, process/fail, idle dwell.
   always_ff @(posedge clk_200kHz) begin
      if (!reset_n) begin
         stateR      <= POWERUP;
         cntR        <= 16'd0;
         errCntR     <= 2'd0;
         sampleR     <= 13'sd0;
         rd_req      <= 1'b0;
         temperature <= 13'sd0;
         temp_valid  <= 1'b0;
         fault       <= 1'b0;
         sample_cnt  <= 8'd0;
         for (int i = 0; i < 4; i++) begin
            tapR[i] <= 13'sd0;
         end
      end else begin
         rd_req <= 1'b0;
         case (stateR)
            POWERUP: begin
               if (cntPlusS >= {5'd0, POWER_UP_TIME}) begin
                  stateR <= REQ;
                  rd_req <= 1'b1;
                  cntR   <= 16'd0;
               end else begin
                  cntR <= cntPlusS[15:0];
               end
            end
            REQ: begin
               stateR <= WAIT;
               cntR   <= 16'd0;
            end
            WAIT: begin
               // A bus error wins over a simultaneous completion.
               if (rd_ack_err) begin
                  stateR <= FAIL;
               end else if (rd_done) begin
                  sampleR <= rd_data[15:3];
                  stateR  <= PROCESS;
               end else if (cntPlusS >= {5'd0, TIMEOUT}) begin
                  stateR <= FAIL;
               end else begin
                  cntR <= cntPlusS[15:0];
               end
            end
            PROCESS: begin
               for (int i = 0; i < 4; i++) begin
                  tapR[i] <= tapNextS[i];
               end
               temperature <= avgS;
               temp_valid  <= 1'b1;
               sample_cnt  <= sample_cnt + 8'd1;
               errCntR     <= 2'd0;
               fault       <= 1'b0;
               stateR      <= IDLE;
               cntR        <= 16'd0;
            end
            FAIL: begin
               errCntR <= errNextS;
               fault   <= (errNextS == MAX_ERR);
               stateR  <= IDLE;
               cntR    <= 16'd0;
            end
            IDLE: begin
               if (cntPlusS >= {1'b0, SAMPLE_PERIOD}) begin
                  stateR <= REQ;
                  rd_req <= 1'b1;
                  cntR   <= 16'd0;
               end else begin
                  cntR <= cntPlusS[15:0];
               end
            end
            default: begin
               stateR <= POWERUP;
               cntR   <= 16'd0;
            end
         endcase
      end
   end

   // Fan decision trails the registered temperature/fault by one cycle.
   always_ff @(posedge clk_200kHz) begin
      if (!reset_n) begin
         fan_on <= 1'b0;
      end else if (fault) begin
         fan_on <= 1'b1;
      end else if (!temp_valid) begin
         fan_on <= 1'b0;
      end else if (temperature >= T_ON) begin
         fan_on <= 1'b1;
      end else if (temperature <= T_OFF) begin
         fan_on <= 1'b0;
      end else begin
         fan_on <= fan_on;
      end
   end

endmodule

// File: tb/tb_adt7420_sample_scheduler.sv
// Self-checking bench for adt7420_sample_scheduler with short timing parameters.
module tb_adt7420_sample_scheduler;

   logic               clk_200kHz = 1'b0;
   logic               reset_n    = 1'b0;
   logic               rd_req;
   logic               rd_done    = 1'b0;
   logic               rd_ack_err = 1'b0;
   logic        [15:0] rd_data    = 16'h0000;
   logic signed [12:0] temperature;
   logic               temp_valid;
   logic               fan_on;
   logic               fault;
   logic        [7:0]  sample_cnt;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   int mdlTaps [4];
   bit mdlValid  = 1'b0;
   int tempExp   = 0;
   int errExp    = 0;
   bit faultExp  = 1'b0;
   bit fanExp    = 1'b0;
   int cntExp    = 0;
   logic signed [12:0] expQ [$];

   adt7420_sample_scheduler #(
      .POWER_UP_TIME(12'd20),
      .SAMPLE_PERIOD(16'd10),
      .TIMEOUT(12'd8),
      .T_ON(13'sd480),
      .T_OFF(13'sd432),
      .MAX_ERR(2'd3)
   ) dut (
      .clk_200kHz(clk_200kHz),
      .reset_n(reset_n),
      .rd_req(rd_req),
      .rd_done(rd_done),
      .rd_ack_err(rd_ack_err),
      .rd_data(rd_data),
      .temperature(temperature),
      .temp_valid(temp_valid),
      .fan_on(fan_on),
      .fault(fault),
      .sample_cnt(sample_cnt)
   );

   always #5 clk_200kHz = ~clk_200kHz;

   task automatic modelFan();
      if (faultExp) fanExp = 1'b1;
      else if (!mdlValid) fanExp = 1'b0;
      else if (tempExp >= 480) fanExp = 1'b1;
      else if (tempExp <= 432) fanExp = 1'b0;
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) mdlTaps[i] = 0;
      mdlValid = 1'b0; tempExp = 0; errExp = 0; faultExp = 1'b0; fanExp = 1'b0; cntExp = 0;
      expQ.delete();
   endtask

   task automatic modelGood(input int s);
      int sum;
      if (!mdlValid) begin
         for (int i = 0; i < 4; i++) mdlTaps[i] = s;
      end else begin
         mdlTaps[3] = mdlTaps[2]; mdlTaps[2] = mdlTaps[1]; mdlTaps[1] = mdlTaps[0]; mdlTaps[0] = s;
      end
      sum = mdlTaps[0] + mdlTaps[1] + mdlTaps[2] + mdlTaps[3];
      tempExp  = sum >>> 2;
      mdlValid = 1'b1;
      errExp   = 0;
      faultExp = 1'b0;
      cntExp   = (cntExp + 1) % 256;
      expQ.push_back(tempExp[12:0]);
      modelFan();
   endtask

   task automatic modelFail();
      if (errExp < 3) errExp++;
      faultExp = (errExp >= 3);
      modelFan();
   endtask

   task automatic doReset();
      reset_n = 1'b0; rd_done = 1'b0; rd_ack_err = 1'b0; rd_data = 16'h0000;
      repeat (3) @(negedge clk_200kHz);
      reset_n = 1'b1;
      modelReset();
   endtask

   task automatic waitReq(input int limit, output int cycles);
      cycles = -1;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk_200kHz);
         if (rd_req === 1'b1) begin
            cycles = k;
            break;
         end
      end
   endtask

   task automatic nextReq(input string tag);
      int cyc;
      waitReq(100, cyc);
      compared++;
      if (cyc < 0) begin
         mismatched++;
         $display("FAIL %s_req: got no rd_req, expected one within 100 cycles", tag);
      end
   endtask

   // kind 0 = rd_done, 1 = rd_ack_err, 2 = both in the same cycle
   task automatic respond(input int kind, input logic [15:0] raw, input int delay, input string tag);
      logic [7:0] cntBefore;
      logic signed [12:0] tempBefore;
      logic signed [12:0] st;
      logic signed [12:0] exp;
      bit seen;
      cntBefore  = sample_cnt;
      tempBefore = temperature;
      st = raw[15:3];
      repeat (delay) @(negedge clk_200kHz);
      rd_data    = raw;
      rd_done    = (kind != 1);
      rd_ack_err = (kind != 0);
      if (kind == 0) modelGood(int'(st));
      else modelFail();
      @(negedge clk_200kHz);
      rd_done = 1'b0; rd_ack_err = 1'b0;
      if (kind == 0) begin
         seen = 1'b0;
         for (int k = 0; k < 8; k++) begin
            if (sample_cnt !== cntBefore) begin
               seen = 1'b1;
               break;
            end
            @(negedge clk_200kHz);
         end
         compared++;
         if (!seen) begin
            mismatched++;
            $display("FAIL %s_output: sample_cnt stuck at %0d, expected %0d", tag, sample_cnt, cntExp);
         end
         exp = expQ.pop_front();
         compared++;
         if (temperature !== exp) begin
            mismatched++;
            $display("FAIL %s_temp: got %0d expected %0d", tag, temperature, exp);
         end
         compared++;
         if (temp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_valid: got %b expected 1", tag, temp_valid);
         end
         compared++;
         if (sample_cnt !== cntExp[7:0]) begin
            mismatched++;
            $display("FAIL %s_cnt: got %0d expected %0d", tag, sample_cnt, cntExp);
         end
         @(negedge clk_200kHz);
      end else begin
         repeat (3) @(negedge clk_200kHz);
         compared++;
         if (sample_cnt !== cntBefore) begin
            mismatched++;
            $display("FAIL %s_cnt: got %0d expected %0d", tag, sample_cnt, cntBefore);
         end
         compared++;
         if (temperature !== tempBefore) begin
            mismatched++;
            $display("FAIL %s_temp: got %0d expected %0d", tag, temperature, tempBefore);
         end
      end
      compared++;
      if (fault !== faultExp) begin
         mismatched++;
         $display("FAIL %s_fault: got %b expected %b", tag, fault, faultExp);
      end
      compared++;
      if (fan_on !== fanExp) begin
         mismatched++;
         $display("FAIL %s_fan: got %b expected %b", tag, fan_on, fanExp);
      end
   endtask

   task automatic test_reset();
      doReset();
      compared += 6;
      if (rd_req !== 1'b0)      begin mismatched++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
      if (temperature !== 13'sd0) begin mismatched++; $display("FAIL reset_temp: got %0d expected 0", temperature); end
      if (temp_valid !== 1'b0)  begin mismatched++; $display("FAIL reset_valid: got %b expected 0", temp_valid); end
      if (fan_on !== 1'b0)      begin mismatched++; $display("FAIL reset_fan: got %b expected 0", fan_on); end
      if (fault !== 1'b0)       begin mismatched++; $display("FAIL reset_fault: got %b expected 0", fault); end
      if (sample_cnt !== 8'd0)  begin mismatched++; $display("FAIL reset_cnt: got %0d expected 0", sample_cnt); end
   endtask

   task automatic test_startup();
      int cyc;
      waitReq(60, cyc);
      compared++;
      if (cyc !== 20) begin
         mismatched++;
         $display("FAIL startup_first_req: got cycle %0d expected 20", cyc);
      end
   endtask

   task automatic test_first_sample();
      respond(0, 16'h0F00, 5, "first");
   endtask

   task automatic test_averaging();
      // 432 with nonzero flag bits, which must be ignored
      for (int i = 0; i < 4; i++) begin
         nextReq("avg");
         respond(0, 16'h0D85, 3, "avg");
      end
   endtask

   task automatic test_negative();
      doReset();
      nextReq("neg");
      respond(0, 16'hFF80, 4, "neg");
      compared++;
      if (temperature !== 13'h1FF0) begin
         mismatched++;
         $display("FAIL neg_raw: got %h expected 1ff0", temperature);
      end
   endtask

   task automatic test_errors();
      int cyc;
      doReset();
      nextReq("err");
      respond(0, 16'h0A00, 2, "err_good");
      for (int i = 0; i < 3; i++) begin
         nextReq("err");
         respond(1, 16'h0F00, 2, "err_nack");
      end
      // Timeout: no response at all
      nextReq("tmo");
      modelFail();
      repeat (12) @(negedge clk_200kHz);
      compared += 3;
      if (fault !== faultExp)   begin mismatched++; $display("FAIL tmo_fault: got %b expected %b", fault, faultExp); end
      if (fan_on !== fanExp)    begin mismatched++; $display("FAIL tmo_fan: got %b expected %b", fan_on, fanExp); end
      if (temperature !== 13'sd320) begin mismatched++; $display("FAIL tmo_temp: got %0d expected 320", temperature); end
      nextReq("recover");
      respond(0, 16'h0A00, 3, "recover");
   endtask

   task automatic test_done_and_err();
      nextReq("both");
      respond(2, 16'h0F00, 2, "both");
      nextReq("both_after");
      respond(0, 16'h0F00, 2, "both_after");
   endtask

   task automatic test_reset_mid_wait();
      int first;
      nextReq("rst_wait");
      repeat (2) @(negedge clk_200kHz);
      reset_n = 1'b0;
      repeat (2) @(negedge clk_200kHz);
      reset_n = 1'b1;
      modelReset();
      first = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_200kHz);
         if (rd_req === 1'b1 && first < 0) first = k;
         rd_done = (k == 3);
         rd_data = 16'h0F00;
         if (k == 10) begin
            compared += 4;
            if (temperature !== 13'sd0) begin mismatched++; $display("FAIL stray_temp: got %0d expected 0", temperature); end
            if (temp_valid !== 1'b0)  begin mismatched++; $display("FAIL stray_valid: got %b expected 0", temp_valid); end
            if (sample_cnt !== 8'd0)  begin mismatched++; $display("FAIL stray_cnt: got %0d expected 0", sample_cnt); end
            if (fan_on !== 1'b0)      begin mismatched++; $display("FAIL stray_fan: got %b expected 0", fan_on); end
         end
      end
      rd_done = 1'b0;
      compared++;
      if (first !== 20) begin
         mismatched++;
         $display("FAIL rst_wait_req: got cycle %0d expected 20", first);
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_first_sample();
      test_averaging();
      test_negative();
      test_errors();
      test_done_and_err();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/adt7420_sample_scheduler.md
Name: adt7420_sample_scheduler

Overview:
Sequences periodic temperature reads from the ADT7420 I2C master and conditions the results for the fan control path. Waits out the sensor power-up time, issues read requests at a fixed interval and supervises each transaction for errors and timeouts. Filters good samples through a 4-tap moving average and drives a hysteretic fan_on decision. Sits between the I2C master and the fan PWM logic, in the clk_200kHz domain.

Parameters:
POWER_UP_TIME, 12'd1950, cycles to wait after reset release before the first read request
SAMPLE_PERIOD, 16'd20000, IDLE dwell in cycles between end of one transaction and next request (min 1)
TIMEOUT, 12'd1000, max cycles from rd_req to rd_done/rd_ack_err before the read is declared failed
T_ON, 13'sd480, fan turn-on threshold, signed 0.0625 C units (30.0 C)
T_OFF, 13'sd432, fan turn-off threshold (27.0 C); T_OFF < T_ON is required
MAX_ERR, 2'd3, consecutive failed reads that assert fault

Ports:
clk_200kHz  in  1  system clock
reset_n  in  1  synchronous, active-low reset
rd_req  out  1  single-cycle read request to the I2C master
rd_done  in  1  single-cycle pulse: read finished, rd_data valid
rd_ack_err  in  1  single-cycle pulse: NACK/bus error on current read
rd_data  in  16  raw ADT7420 temperature register; [15:3] = signed 13-bit temp, [2:0] ignored
temperature  out  13  signed averaged temperature, 0.0625 C/LSB
temp_valid  out  1  high once at least one good sample has been averaged
fan_on  out  1  hysteretic fan request; forced high while fault
fault  out  1  MAX_ERR consecutive failed reads
sample_cnt  out  8  good samples taken, wraps 255->0

Behaviour:
- Reset (reset_n=0 at a clk_200kHz edge): state=POWERUP, all counters 0, rd_req=0, temperature=0, temp_valid=0, fan_on=0, fault=0, sample_cnt=0, average buffer cleared. Reset mid-transaction abandons it; a late rd_done is ignored.
- POWERUP: counts POWER_UP_TIME cycles, then -> REQ. No rd_req is issued before then.
- REQ: rd_req=1 for exactly one cycle; timeout counter cleared; -> WAIT.
- WAIT: timeout counter increments each cycle.
  - rd_ack_err=1 -> FAIL (takes priority over a same-cycle rd_done).
  - rd_done=1 -> PROCESS; rd_data[15:3] is captured in that cycle.
  - Counter reaches TIMEOUT-1 with no response -> FAIL.
- rd_done/rd_ack_err outside WAIT: ignored.
- PROCESS (1 cycle):
  - First good sample since reset: all 4 taps are preloaded with it.
  - Otherwise the sample shifts into the 4-tap buffer.
  - Sum is 15-bit signed; temperature = sum >>> 2 (arithmetic), registered at the end of PROCESS.
  - temp_valid=1; sample_cnt++; consecutive-error count cleared; fault cleared.
  - -> IDLE.
- FAIL (1 cycle): consecutive-error count increments, saturating at MAX_ERR; fault=1 when it reaches MAX_ERR. The average buffer and temperature are unchanged. -> IDLE.
- IDLE: dwells SAMPLE_PERIOD cycles, then -> REQ.
- fan_on is updated one cycle after temperature updates:
  - Set when temperature >= T_ON (signed compare).
  - Cleared when temperature <= T_OFF.
  - Held between the thresholds.
  - Forced to 1 while fault=1.
  - Stays 0 while temp_valid=0 and fault=0.
  - When fault clears, fan_on re-evaluates from the new temperature.
- Latency: rd_done at cycle N -> temperature valid at N+2 -> fan_on at N+3.
- Negative temperatures are fully supported (sign-extended through the sum).

Test Plan:
- Startup: POWER_UP_TIME=20, SAMPLE_PERIOD=10 -> first rd_req exactly 20 cycles after reset release; no rd_req earlier.
- First sample: rd_done 5 cycles after rd_req with rd_data=16'h0F00 (temp 480) -> temperature=480, temp_valid=1, sample_cnt=1, fan_on=1 on the following cycle.
- Averaging and hysteresis: samples 480, 432, 432, 432 -> temperature 468, 456, 444, 432. fan_on stays 1 until the average reaches 432, then clears.
- Negative value: rd_data=16'hFF80 (temp -16) on the first sample -> temperature=-16 (13'h1FF0), fan_on=0.
- Errors: three reads ending in rd_ack_err, then one timeout (TIMEOUT=8) -> fault=1 after the third failure, fan_on=1, temperature unchanged. Next good read clears fault.
- Corner cases:
  - rd_done and rd_ack_err in the same cycle -> treated as a failure.
  - reset_n low during WAIT, then a stray rd_done -> outputs at reset values; the next rd_req occurs only after POWER_UP_TIME.
